// File: rtl/pulse_spacer.sv
// pulse_spacer: queues single-cycle event pulses and re-emits them one at a
// time. Successive out_pulse rising edges are at least GAP clocks apart, so a
// downstream toggle synchronizer never merges two events.
//
// Ports:
//   clk        single clock, all logic on posedge
//   rst        synchronous reset, active-high, highest priority
//   in_pulse   event strobe, one event per high cycle
//   clr_ovf    clears the sticky overflow flag
//   out_pulse  spaced one-cycle event strobe (registered)
//   pending    accepted events not yet emitted (registered)
//   busy       high while holding off or backlog non-zero (registered)
//   overflow   sticky, set when an event is dropped (registered)
module pulse_spacer #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_pulse,
  input  logic             clr_ovf,
  output logic             out_pulse,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             overflow
);

  localparam int unsigned      GAP_W    = 8;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    READY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [GAP_W-1:0] gap_cnt, gap_next;
  logic [CNT_W-1:0] pending_next;
  logic             out_next;
  logic             busy_next;
  logic             ovf_next;
  logic             emit;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= READY;
      gap_cnt   <= '0;
      out_pulse <= 1'b0;
      pending   <= '0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      gap_cnt   <= gap_next;
      out_pulse <= out_next;
      pending   <= pending_next;
      busy      <= busy_next;
      overflow  <= ovf_next;
    end
  end

  // Next-state, spacing counter, backlog and overflow
  always_comb begin
    state_next   = state;
    gap_next     = gap_cnt;
    out_next     = 1'b0;
    pending_next = pending;
    ovf_next     = overflow & ~clr_ovf;
    emit         = 1'b0;

    case (state)
      READY: begin
        // An idle spacer forwards a fresh event immediately (bypass)
        emit = in_pulse | (pending != '0);
        if (emit) begin
          out_next   = 1'b1;
          gap_next   = GAP_LOAD;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (gap_cnt == GAP_W'(1)) begin
          state_next = READY;
          gap_next   = '0;
        end else begin
          gap_next = gap_cnt - GAP_W'(1);
        end
      end
      default: state_next = READY;
    endcase

    // Arrival and emission in one cycle cancel, even when the backlog is full
    if (in_pulse && !emit) begin
      if (pending == CNT_MAX) begin
        ovf_next = 1'b1;
      end else begin
        pending_next = pending + CNT_W'(1);
      end
    end else if (!in_pulse && emit) begin
      pending_next = pending - CNT_W'(1);
    end

    // Registered equivalent of (state==HOLD) | (pending!=0)
    busy_next = (state_next == HOLD) | (pending_next != '0);
  end

endmodule

// File: tb/tb_pulse_spacer.sv
// Scoreboard bench for pulse_spacer. Instance a uses CNT_W=4, instance b uses
// CNT_W=2 for saturation; both GAP=4. Cycle numbers are relative to t0, the
// first cycle after a reset pulse; an input driven during cycle r is sampled at
// the edge ending cycle r.
module tb_pulse_spacer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_a, clr_a, in_b, clr_b;
  logic       out_a, busy_a, ovf_a;
  logic       out_b, busy_b, ovf_b;
  logic [3:0] pend_a;
  logic [1:0] pend_b;

  int cyc    = 0;
  int t0     = 0;
  int n_chk  = 0;
  int n_fail = 0;
  int qa[$];
  int qb[$];

  pulse_spacer #(.CNT_W(4), .GAP(4)) dut_a (
    .clk(clk), .rst(rst), .in_pulse(in_a), .clr_ovf(clr_a),
    .out_pulse(out_a), .pending(pend_a), .busy(busy_a), .overflow(ovf_a)
  );

  pulse_spacer #(.CNT_W(2), .GAP(4)) dut_b (
    .clk(clk), .rst(rst), .in_pulse(in_b), .clr_ovf(clr_b),
    .out_pulse(out_b), .pending(pend_b), .busy(busy_b), .overflow(ovf_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @rel %0d: got %0d expected %0d", name, cyc - t0, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_a = 1'b0; clr_a = 1'b0; in_b = 1'b0; clr_b = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    t0 = cyc;
  endtask

  // Monitor: every out_pulse must match the oldest expected cycle
  initial begin
    forever begin
      @(negedge clk);
      if (out_a === 1'b1) begin
        if (qa.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL out_a unexpected pulse at rel %0d", cyc - t0);
        end else begin
          chk("out_a cycle", 32'(cyc - t0), 32'(qa.pop_front()));
        end
      end
      if (out_b === 1'b1) begin
        if (qb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL out_b unexpected pulse at rel %0d", cyc - t0);
        end else begin
          chk("out_b cycle", 32'(cyc - t0), 32'(qb.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_a = 1'b0; clr_a = 1'b0; in_b = 1'b0; clr_b = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst out_a", 32'(out_a), 0);
    chk("rst pend_a", 32'(pend_a), 0);
    chk("rst busy_a", 32'(busy_a), 0);
    chk("rst ovf_a", 32'(ovf_a), 0);
    chk("rst out_b", 32'(out_b), 0);
    chk("rst pend_b", 32'(pend_b), 0);
    chk("rst busy_b", 32'(busy_b), 0);
    chk("rst ovf_b", 32'(ovf_b), 0);

    // Single event: bypass, one pulse at 11, busy through 13
    do_reset();
    qa.push_back(11);
    for (int r = 1; r <= 20; r++) begin
      @(negedge clk);
      in_a = (r == 10);
      if (r == 11) begin
        chk("single busy@11", 32'(busy_a), 1);
        chk("single pend@11", 32'(pend_a), 0);
      end
      if (r == 13) chk("single busy@13", 32'(busy_a), 1);
      if (r == 14) chk("single busy@14", 32'(busy_a), 0);
    end

    // Burst of 5: peak backlog 3 (the fifth arrival coincides with the second emit)
    do_reset();
    qa.push_back(11); qa.push_back(15); qa.push_back(19); qa.push_back(23); qa.push_back(27);
    for (int r = 1; r <= 35; r++) begin
      @(negedge clk);
      in_a = (r >= 10 && r <= 14);
      if (r == 14) chk("burst pend@14", 32'(pend_a), 3);
      if (r == 15) chk("burst pend@15", 32'(pend_a), 3);
      if (r == 19) chk("burst pend@19", 32'(pend_a), 2);
      if (r == 23) chk("burst pend@23", 32'(pend_a), 1);
      if (r == 27) begin
        chk("burst pend@27", 32'(pend_a), 0);
        chk("burst busy@27", 32'(busy_a), 1);
      end
      if (r == 30) begin
        chk("burst busy@30", 32'(busy_a), 0);
        chk("burst ovf@30", 32'(ovf_a), 0);
      end
    end

    // Saturation on CNT_W=2, then clear race (drop + clr) and a plain clear
    do_reset();
    qb.push_back(11); qb.push_back(15); qb.push_back(19); qb.push_back(23); qb.push_back(27);
    for (int r = 1; r <= 35; r++) begin
      @(negedge clk);
      in_b  = (r >= 10 && r <= 16);
      clr_b = (r == 16 || r == 17);
      if (r == 14) chk("ovf pend@14", 32'(pend_b), 3);
      if (r == 15) chk("ovf flag@15", 32'(ovf_b), 0);
      if (r == 16) begin
        chk("ovf flag@16", 32'(ovf_b), 1);
        chk("ovf pend@16", 32'(pend_b), 3);
      end
      if (r == 17) chk("ovf set wins@17", 32'(ovf_b), 1);
      if (r == 18) chk("ovf cleared@18", 32'(ovf_b), 0);
      if (r == 19) chk("ovf pend@19", 32'(pend_b), 2);
      if (r == 30) begin
        chk("ovf busy@30", 32'(busy_b), 0);
        chk("ovf flag@30", 32'(ovf_b), 0);
      end
    end

    // Reset mid-burst: backlog 3 in HOLD is discarded, no later pulses
    do_reset();
    qa.push_back(11); qa.push_back(15);
    for (int r = 1; r <= 40; r++) begin
      @(negedge clk);
      in_a = (r >= 10 && r <= 14);
      rst  = (r == 15);
      if (r == 15) begin
        chk("midrst pend@15", 32'(pend_a), 3);
        chk("midrst busy@15", 32'(busy_a), 1);
      end
      if (r == 16) begin
        chk("midrst pend@16", 32'(pend_a), 0);
        chk("midrst busy@16", 32'(busy_a), 0);
        chk("midrst out@16", 32'(out_a), 0);
      end
    end

    // Exact-rate input: every event bypasses, backlog stays 0
    do_reset();
    qa.push_back(11); qa.push_back(15); qa.push_back(19);
    for (int r = 1; r <= 26; r++) begin
      @(negedge clk);
      in_a = (r == 10 || r == 14 || r == 18);
      if (r >= 10 && r <= 25) chk("rate pend", 32'(pend_a), 0);
      if (r == 23) chk("rate busy@23", 32'(busy_a), 0);
    end

    @(negedge clk);
    chk("qa drained", 32'(qa.size()), 0);
    chk("qb drained", 32'(qb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
